// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - pushbutton synchroniser, debounce FSM, press/release strobes and enable
// Optional toggle latch on enable is built when BUTTON_TOGGLE_EN is defined.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1330000,
  parameter int CNT_WIDTH       = 21,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic button_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic enable
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic                 POLARITY = (ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 btn_n;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pressed_q, pressed_d;
  logic                 press_pulse_q, press_pulse_d;
  logic                 release_pulse_q, release_pulse_d;

  assign btn_n = button_raw ^ POLARITY;

  always_comb begin
    sync1_d         = btn_n;
    sync2_d         = sync1_q;
    state_d         = state_q;
    cnt_d           = cnt_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;

    // Any sample of the old level during a WAIT state restarts qualification.
    case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d       = PRESSED;
          press_pulse_d = 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d         = RELEASED;
          release_pulse_d = 1'b1;
          cnt_d           = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase

    pressed_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      state_q         <= RELEASED;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

`ifdef BUTTON_TOGGLE_EN
  logic enable_q, enable_d;

  // Flips on the same edge press_pulse rises; release never touches it.
  always_comb begin
    enable_d = enable_q ^ press_pulse_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable_d;
    end
  end

  assign enable = enable_q;
`else
  assign enable = pressed_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4)
module tb_button_debouncer;

  logic clock = 1'b0;
  logic reset;
  logic button_raw;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic enable;

  int   edge_n = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic exp_en = 1'b0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (3),
    .ACTIVE_LOW     (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .button_raw   (button_raw),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .enable       (enable)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
  endtask

  task automatic quiet(input int n, input logic exp_pressed);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("quiet_pressed", pressed, exp_pressed);
      chk("quiet_press_pulse", press_pulse, 1'b0);
      chk("quiet_release_pulse", release_pulse, 1'b0);
      chk("quiet_enable", enable, exp_en);
    end
  endtask

  // Caller has just driven the pin to the pressed level after an edge.
  task automatic accept_press();
    quiet(5, 1'b0);
    tick();
`ifdef BUTTON_TOGGLE_EN
    exp_en = ~exp_en;
`else
    exp_en = 1'b1;
`endif
    chk("press_pressed", pressed, 1'b1);
    chk("press_pulse_hi", press_pulse, 1'b1);
    chk("press_no_release", release_pulse, 1'b0);
    chk("press_enable", enable, exp_en);
    tick();
    chk("press_pulse_lo", press_pulse, 1'b0);
    chk("press_held", pressed, 1'b1);
    chk("press_enable_hold", enable, exp_en);
  endtask

  task automatic accept_release();
    quiet(5, 1'b1);
    tick();
`ifndef BUTTON_TOGGLE_EN
    exp_en = 1'b0;
`endif
    chk("release_pressed", pressed, 1'b0);
    chk("release_pulse_hi", release_pulse, 1'b1);
    chk("release_no_press", press_pulse, 1'b0);
    chk("release_enable", enable, exp_en);
    tick();
    chk("release_pulse_lo", release_pulse, 1'b0);
    chk("release_enable_hold", enable, exp_en);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pressed"}, pressed, 1'b0);
    chk({tag, "_press_pulse"}, press_pulse, 1'b0);
    chk({tag, "_release_pulse"}, release_pulse, 1'b0);
    chk({tag, "_enable"}, enable, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    button_raw = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // Clean press: pin falls at edge 10, accepted at edge 16.
    while (edge_n < 10) quiet(1, 1'b0);
    button_raw = 1'b0;
    accept_press();

    button_raw = 1'b1;
    accept_release();
    quiet(2, 1'b0);

    // Bounce: 3 low, 1 high, then low; accept 6 edges after the last fall.
    button_raw = 1'b0;
    quiet(3, 1'b0);
    button_raw = 1'b1;
    quiet(1, 1'b0);
    button_raw = 1'b0;
    accept_press();
    button_raw = 1'b1;
    accept_release();
    quiet(2, 1'b0);

    for (int k = 0; k < 3; k++) begin
      button_raw = 1'b0;
      accept_press();
      quiet(2, 1'b1);
      button_raw = 1'b1;
      accept_release();
      quiet(2, 1'b0);
    end

    // Reset two cycles into WAIT_PRESS, button held through and after.
    button_raw = 1'b0;
    quiet(4, 1'b0);
    reset = 1'b1;
    tick();
    chk_all_zero("midreset_a");
    tick();
    chk_all_zero("midreset_b");
    reset  = 1'b0;
    exp_en = 1'b0;
    accept_press();

    button_raw = 1'b1;
    accept_release();
    quiet(3, 1'b0);

    // Single-cycle glitch must never qualify.
    button_raw = 1'b0;
    quiet(1, 1'b0);
    button_raw = 1'b1;
    quiet(12, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
